// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller.
//   - FSM state encoding (kept as plain 2-bit constants so older blocks that
//     compare raw state codes stay compatible)
//   - architectural zero register index
//   - hazard bundle type and a source/destination match helper
package pipe_ctrl_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic memWait;
        logic branch;
        logic loadUse;
    } hazard_t;

    // True when an ID source operand is really read and names the EX destination.
    function automatic logic regMatch(input logic useSrc,
                                      input logic [4:0] srcReg,
                                      input logic [4:0] dstReg);
        return useSrc && (srcReg == dstReg);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Ports:
//   clk  in  1   clock, rising edge
//   rst  in  1   asynchronous reset, active-low
//   inc  in  1   count this cycle
//   q    out W   current count; holds at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline sequencing controller beside the EX-stage forwarding unit.
// Detects hazards forwarding cannot resolve (load-use, taken branch/jump,
// multi-cycle data-memory wait) and drives the per-stage stall/flush enables.
// Also keeps saturating stall/flush performance counters and a sticky
// memory-timeout error.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | no memory wait in progress
// MEM_WAIT | data memory is stalling the pipe; waitCnt counts wait cycles
// ERROR    | wait exceeded TIMEOUT; stalls continue until memory responds
//
// Ports:
//   clk, rst                      clock (rising) / async active-low reset
//   Rs1D, Rs2D, UseRs1D, UseRs2D  ID-stage source registers and their use flags
//   RdE, MemReadE                 EX-stage destination and load flag
//   PCSrcE                        branch taken / jump resolved in EX
//   MemReqM, MemReadyM            MEM-stage access outstanding / completing
//   StallF/D/E/M                  hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E/W                    bubble into IF/ID, ID/EX, MEM/WB
//   MemTimeout                    sticky memory-timeout error
//   StallCount, FlushCount        saturating performance counters
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int TMO_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic             UseRs1D,
    input  logic             UseRs2D,
    input  logic [4:0]       RdE,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(TIMEOUT - 1);

    hazard_t          hz;
    logic [1:0]       state;
    logic [TMO_W-1:0] waitCnt;
    logic             branchFlush;

    assign hz.memWait = MemReqM & ~MemReadyM;
    assign hz.branch  = PCSrcE;
    assign hz.loadUse = MemReadE && (RdE != REG_ZERO) &&
                        (regMatch(UseRs1D, Rs1D, RdE) || regMatch(UseRs2D, Rs2D, RdE));

    // A branch during a memory wait is not lost: the stall holds the branch
    // in EX, so it is acted on the first cycle after the wait ends.
    assign branchFlush = hz.branch & ~hz.memWait;

    // Outputs are gated by rst directly so they drop the instant reset asserts.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            if (hz.memWait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (hz.branch) begin
                // The dependent instruction is squashed, so load-use is moot.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (hz.loadUse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // The cycle that enters MEM_WAIT is already the first wait cycle, hence
    // waitCnt starts at 1 and ERROR is reached after exactly TIMEOUT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            waitCnt    <= '0;
            MemTimeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.memWait) begin
                        state   <= MEM_WAIT;
                        waitCnt <= TMO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!hz.memWait) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else if (waitCnt >= WAIT_LAST) begin
                        state      <= ERROR;
                        MemTimeout <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                ERROR: begin
                    if (!hz.memWait) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end
                end
                default: begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) uStallCnt (
        .clk (clk),
        .rst (rst),
        .inc (StallF),
        .q   (StallCount)
    );

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .clk (clk),
        .rst (rst),
        .inc (branchFlush),
        .q   (FlushCount)
    );

endmodule
